// File: rtl/cve2_sleep_ctrl_if.sv
// Core-side sleep/wake signalling and clock-gate enable bundle for cve2_sleep_ctrl.
// Counter outputs are only populated when CVE2_SLEEP_CTRL_STATS_EN is defined.
interface cve2_sleep_ctrl_if;
  logic        sleep_req_i;
  logic        core_busy_i;
  logic        irq_pending_i;
  logic        debug_req_i;
  logic        stats_clr_i;
  logic        clk_en_o;
  logic        core_sleep_o;
  logic        wake_o;
  logic [31:0] gated_cycles_o;
  logic [15:0] sleep_cnt_o;

  modport master (
    output sleep_req_i, core_busy_i, irq_pending_i, debug_req_i, stats_clr_i,
    input  clk_en_o, core_sleep_o, wake_o, gated_cycles_o, sleep_cnt_o
  );

  modport slave (
    input  sleep_req_i, core_busy_i, irq_pending_i, debug_req_i, stats_clr_i,
    output clk_en_o, core_sleep_o, wake_o, gated_cycles_o, sleep_cnt_o
  );
endinterface

// File: rtl/cve2_sleep_ctrl.sv
// Core clock-gate enable driver: drains WFI requests, gates the clock, restores on irq/debug.
// Define CVE2_SLEEP_CTRL_STATS_EN to build the gated-cycle and sleep-entry counters.
//
// state    | meaning
// ST_RUN   | clock running, watching for a sleep request
// ST_DRAIN | sleep requested, counting quiet cycles before gating
// ST_GATED | clock gated, waiting for irq/debug
// ST_WAKE  | clock restored, holding the minimum run window
module cve2_sleep_ctrl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input logic           clk_i,
  input logic           rst_ni,
  cve2_sleep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_GATED, ST_WAKE} state_e;

  localparam logic [7:0] IDLE_LOAD = 8'(IDLE_CYCLES);
  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES);

  state_e     r_state;
  logic [7:0] r_cnt;
  logic       r_clk_en;
  logic       r_core_sleep;
  logic       r_wake;
  logic       w_wake_evt;
  logic       w_gate_entry;

  assign w_wake_evt   = bus.irq_pending_i | bus.debug_req_i;
  assign w_gate_entry = (r_state == ST_DRAIN) & ~w_wake_evt & bus.sleep_req_i &
                        ~bus.core_busy_i & (r_cnt == 8'd0);

  // clk_en_o only ever changes on a rising edge so the gate latch sees a stable enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_RUN;
      r_cnt        <= 8'd0;
      r_clk_en     <= 1'b1;
      r_core_sleep <= 1'b0;
      r_wake       <= 1'b0;
    end else begin
      r_wake <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_clk_en     <= 1'b1;
          r_core_sleep <= 1'b0;
          if (bus.sleep_req_i && !w_wake_evt) begin
            r_state <= ST_DRAIN;
            r_cnt   <= IDLE_LOAD;
          end
        end
        ST_DRAIN: begin
          if (w_wake_evt || !bus.sleep_req_i) begin
            r_state <= ST_RUN;
          end else if (bus.core_busy_i) begin
            r_cnt <= IDLE_LOAD;
          end else if (r_cnt == 8'd0) begin
            r_state      <= ST_GATED;
            r_clk_en     <= 1'b0;
            r_core_sleep <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_GATED: begin
          if (w_wake_evt) begin
            r_state      <= ST_WAKE;
            r_clk_en     <= 1'b1;
            r_core_sleep <= 1'b0;
            r_wake       <= 1'b1;
            r_cnt        <= WAKE_LOAD;
          end
        end
        ST_WAKE: begin
          if (r_cnt == 8'd0) r_state <= ST_RUN;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        default: begin
          r_state      <= ST_RUN;
          r_clk_en     <= 1'b1;
          r_core_sleep <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clk_en_o     = r_clk_en;
  assign bus.core_sleep_o = r_core_sleep;
  assign bus.wake_o       = r_wake;

`ifdef CVE2_SLEEP_CTRL_STATS_EN
  logic [31:0] r_gated_cycles;
  logic [15:0] r_sleep_cnt;

  // Clear wins over increment; both counters stick at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gated_cycles <= 32'd0;
      r_sleep_cnt    <= 16'd0;
    end else if (bus.stats_clr_i) begin
      r_gated_cycles <= 32'd0;
      r_sleep_cnt    <= 16'd0;
    end else begin
      if (r_state == ST_GATED && r_gated_cycles != 32'hFFFF_FFFF)
        r_gated_cycles <= r_gated_cycles + 32'd1;
      if (w_gate_entry && r_sleep_cnt != 16'hFFFF)
        r_sleep_cnt <= r_sleep_cnt + 16'd1;
    end
  end

  assign bus.gated_cycles_o = r_gated_cycles;
  assign bus.sleep_cnt_o    = r_sleep_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats     = bus.stats_clr_i | w_gate_entry;
  assign bus.gated_cycles_o = 32'd0;
  assign bus.sleep_cnt_o    = 16'd0;
`endif

endmodule

// File: tb/tb_cve2_sleep_ctrl.sv
// Directed and randomized bench for cve2_sleep_ctrl against a timestamp-based reference model.
// Counter expectations follow CVE2_SLEEP_CTRL_STATS_EN the same way the design does.
module tb_cve2_sleep_ctrl;
  localparam int IDLE = 4;
  localparam int WAKE = 2;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  cve2_sleep_ctrl_if bus ();

  cve2_sleep_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;

  // Model: gating is a matter of edge timestamps, not of a state machine.
  longint      t          = 0;
  longint      run_from   = 0;
  longint      quiet_from = 0;
  bit          m_gated    = 0;
  bit          m_draining = 0;
  bit          m_wake     = 0;
  logic [31:0] m_gc       = '0;
  logic [15:0] m_sc       = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_gc();
`ifdef CVE2_SLEEP_CTRL_STATS_EN
    return m_gc;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_sc();
`ifdef CVE2_SLEEP_CTRL_STATS_EN
    return {16'd0, m_sc};
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_gated    = 0;
    m_draining = 0;
    m_wake     = 0;
    run_from   = t;
    m_gc       = '0;
    m_sc       = '0;
  endtask

  task automatic model_edge(input bit sr, input bit busy, input bit irq, input bit dbg, input bit clr);
    bit we      = irq | dbg;
    bit was_g   = m_gated;
    bit entered = 0;
    m_wake = 0;
    if (m_gated) begin
      if (we) begin
        m_gated  = 0;
        m_wake   = 1;
        run_from = t + WAKE + 2;
      end
    end else if (t < run_from) begin
      // minimum run window after a wake: requests ignored
    end else if (!m_draining) begin
      if (sr && !we) begin
        m_draining = 1;
        quiet_from = t + 1;
      end
    end else if (we || !sr) begin
      m_draining = 0;
    end else if (busy) begin
      quiet_from = t + 1;
    end else if (t >= quiet_from + IDLE) begin
      m_draining = 0;
      m_gated    = 1;
      entered    = 1;
    end
    if (clr) begin
      m_gc = '0;
      m_sc = '0;
    end else begin
      if (was_g && m_gc != 32'hFFFF_FFFF) m_gc = m_gc + 1;
      if (entered && m_sc != 16'hFFFF) m_sc = m_sc + 1;
    end
  endtask

  task automatic cyc(input bit sr, input bit busy, input bit irq, input bit dbg, input bit clr);
    bus.sleep_req_i   = sr;
    bus.core_busy_i   = busy;
    bus.irq_pending_i = irq;
    bus.debug_req_i   = dbg;
    bus.stats_clr_i   = clr;
    @(posedge clk_i);
    model_edge(sr, busy, irq, dbg, clr);
    t++;
    #1;
    chk("clk_en", {31'd0, bus.clk_en_o}, {31'd0, !m_gated});
    chk("core_sleep", {31'd0, bus.core_sleep_o}, {31'd0, m_gated});
    chk("wake", {31'd0, bus.wake_o}, {31'd0, m_wake});
    chk("gated_cycles", bus.gated_cycles_o, exp_gc());
    chk("sleep_cnt", {16'd0, bus.sleep_cnt_o}, exp_sc());
  endtask

  initial begin
    bus.sleep_req_i   = 0;
    bus.core_busy_i   = 0;
    bus.irq_pending_i = 0;
    bus.debug_req_i   = 0;
    bus.stats_clr_i   = 0;
    #12;
    chk("rst_clk_en", {31'd0, bus.clk_en_o}, 32'd1);
    chk("rst_core_sleep", {31'd0, bus.core_sleep_o}, 32'd0);
    chk("rst_wake", {31'd0, bus.wake_o}, 32'd0);
    chk("rst_gated_cycles", bus.gated_cycles_o, 32'd0);
    chk("rst_sleep_cnt", {16'd0, bus.sleep_cnt_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1;
    model_reset();
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Entry latency: edge 0 samples the request, gated after edge IDLE+1.
    repeat (IDLE + 1) cyc(1, 0, 0, 0, 0);
    chk("entry_not_yet", {31'd0, bus.clk_en_o}, 32'd1);
    cyc(1, 0, 0, 0, 0);
    chk("entry_gated", {31'd0, bus.clk_en_o}, 32'd0);
    chk("entry_core_sleep", {31'd0, bus.core_sleep_o}, 32'd1);

    // Dropping the request alone must not wake a frozen core.
    repeat (10) cyc(0, 0, 0, 0, 0);
    chk("no_wake_on_req_drop", {31'd0, bus.clk_en_o}, 32'd0);
`ifdef CVE2_SLEEP_CTRL_STATS_EN
    chk("gated_ten", bus.gated_cycles_o, 32'd10);
    chk("sleep_cnt_one", {16'd0, bus.sleep_cnt_o}, 32'd1);
`endif

    // Wake on irq with request held: dwell, RUN, DRAIN, then gate again.
    cyc(1, 0, 1, 0, 0);
    chk("wake_clk_en", {31'd0, bus.clk_en_o}, 32'd1);
    chk("wake_pulse", {31'd0, bus.wake_o}, 32'd1);
    cyc(1, 0, 0, 0, 0);
    chk("wake_pulse_end", {31'd0, bus.wake_o}, 32'd0);
    repeat (WAKE + IDLE + 1) cyc(1, 0, 0, 0, 0);
    chk("regate_not_yet", {31'd0, bus.clk_en_o}, 32'd1);
    cyc(1, 0, 0, 0, 0);
    chk("regate", {31'd0, bus.clk_en_o}, 32'd0);

    cyc(0, 0, 0, 1, 0);
    repeat (WAKE + 2) cyc(0, 0, 0, 0, 0);

    // Busy pulse at edge 3 pushes gating from edge 5 to edge 8.
    repeat (3) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    repeat (IDLE) cyc(1, 0, 0, 0, 0);
    chk("busy_not_at_5", {31'd0, bus.clk_en_o}, 32'd1);
    cyc(1, 0, 0, 0, 0);
    chk("busy_gate_at_8", {31'd0, bus.clk_en_o}, 32'd0);
    cyc(0, 0, 1, 0, 0);
    repeat (WAKE + 2) cyc(0, 0, 0, 0, 0);

    // Debug arriving with the count at zero aborts to RUN.
    repeat (IDLE + 1) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    chk("abort_clk_en", {31'd0, bus.clk_en_o}, 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("abort_still_on", {31'd0, bus.clk_en_o}, 32'd1);

    // Request together with wake in RUN is not accepted.
    repeat (IDLE + 3) cyc(1, 0, 1, 0, 0);
    chk("req_with_irq", {31'd0, bus.clk_en_o}, 32'd1);
    repeat (IDLE + 5) cyc(1, 0, 0, 0, 0);

    // Clear while gated, then counting resumes.
    cyc(1, 0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
`ifdef CVE2_SLEEP_CTRL_STATS_EN
    chk("clr_resume", bus.gated_cycles_o, 32'd3);
    chk("clr_sleep_cnt", {16'd0, bus.sleep_cnt_o}, 32'd0);
`endif
    cyc(0, 0, 1, 0, 0);

    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2,
          $urandom_range(0, 19) == 0, $urandom_range(0, 32) == 0,
          $urandom_range(0, 24) == 0);
    end

    // Asynchronous reset while gated.
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 20 && !m_gated; i++) cyc(1, 0, 0, 0, 0);
    chk("reach_gated", {31'd0, bus.clk_en_o}, 32'd0);
    #2;
    rst_ni = 0;
    #1;
    chk("async_rst_clk_en", {31'd0, bus.clk_en_o}, 32'd1);
    chk("async_rst_core_sleep", {31'd0, bus.core_sleep_o}, 32'd0);
    chk("async_rst_sleep_cnt", {16'd0, bus.sleep_cnt_o}, 32'd0);
    bus.sleep_req_i = 0;
    @(posedge clk_i);
    #1;
    chk("in_rst_clk_en", {31'd0, bus.clk_en_o}, 32'd1);
    @(negedge clk_i);
    rst_ni = 1;
    model_reset();
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (IDLE + 2) cyc(1, 0, 0, 0, 0);
    chk("post_rst_gate", {31'd0, bus.clk_en_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
